// File: rtl/mold_pkg.sv
// Shared definitions for the MoldUDP64 ingress path: bus widths, header
// byte offsets within the UDP payload, the end-of-session marker and the
// header phase encoding.
package mold_pkg;

   localparam int AXI_DATA_W  = 64;
   localparam int AXI_KEEP_W  = 8;
   localparam int ML_W        = 16;

   // Byte offsets of the header fields within the UDP payload
   localparam int SID_OFF     = 0;
   localparam int SEQ_OFF     = 10;
   localparam int CNT_OFF     = 18;
   localparam int MSG_LEN_OFF = 20;

   // Message count value that marks the end of a session
   localparam logic [15:0] MSG_CNT_EOS = 16'hFFFF;

   // Header beat phase: three header beats, then payload
   typedef enum logic [1:0] {
      H0      = 2'd0,
      H1      = 2'd1,
      H2      = 2'd2,
      PAYLOAD = 2'd3
   } mold_state_e;

endpackage

// File: rtl/keep_thermo_cnt.sv
// Counts the run of ones starting at bit 0 of a byte-enable vector.
// Bits after the first zero are ignored, so a malformed keep never
// reports bytes beyond a hole.
module keep_thermo_cnt #(
   parameter int D_W  = 8,
   parameter int D_LW = 4
) (
   input  logic [D_W-1:0]  data_i,
   output logic [D_LW-1:0] cnt_o
);

   logic [D_LW-1:0] cnt_s;
   logic            run_s;

   // Walk up from bit 0, counting until the first cleared bit
   always_comb begin
      cnt_s = {D_LW{1'b0}};
      run_s = 1'b1;
      for (int i = 0; i < D_W; i++) begin
         if (run_s && data_i[i]) begin
            cnt_s = cnt_s + {{(D_LW-1){1'b0}}, 1'b1};
         end else begin
            run_s = 1'b0;
         end
      end
   end

   assign cnt_o = cnt_s;

endmodule

// File: rtl/mold_header_rx.sv
// MoldUDP64 header parser. Tracks which header beat is on the bus and
// exposes session, sequence number and message count straight from the
// current beat with no added latency. Beats after the header are flagged
// as payload for the message splitter downstream.
module mold_header_rx #(
   parameter int AXI_DATA_W = 64,
   parameter int AXI_KEEP_W = 8,
   parameter int KEEP_LW    = 4,
   parameter int ML_W       = 16
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  axis_tvalid_i,
   input  logic [AXI_KEEP_W-1:0] axis_tkeep_i,
   input  logic [AXI_DATA_W-1:0] axis_tdata_i,
   input  logic                  axis_tlast_i,
   output logic                  axis_tready_o,
   output logic                  sid_p0_v_o,
   output logic [63:0]           sid_p0_o,
   output logic                  sid_p1_v_o,
   output logic [15:0]           sid_p1_o,
   output logic                  seq_num_p0_v_o,
   output logic [47:0]           seq_num_p0_o,
   output logic                  seq_num_p1_v_o,
   output logic [15:0]           seq_num_p1_o,
   output logic                  msg_cnt_v_o,
   output logic [ML_W-1:0]       msg_cnt_o,
   output logic                  eos_o,
   output logic [KEEP_LW-1:0]    beat_len_o,
   output logic                  payload_v_o,
   output logic                  hdr_err_o
);

   import mold_pkg::*;

   // Lane positions of the fields inside their beats (H1 starts at byte 8,
   // H2 at byte 16)
   localparam int SID0_LO_BIT  = (SID_OFF - 0) * 8;
   localparam int SEQ0_LO_BIT  = (SEQ_OFF - 8) * 8;
   localparam int CNT_LO_BIT   = (CNT_OFF - 16) * 8;
   // Bytes of H2 needed to hold the whole message count
   localparam int CNT_END_LANE = CNT_OFF + 2 - 16;
   // Bytes of H2 that are still header; anything beyond is message data
   localparam int MSG_LANE     = MSG_LEN_OFF - 16;

   mold_state_e      state_r;
   logic [KEEP_LW-1:0] beat_len_s;
   logic             beat_ok_s;
   logic             in_h0_s;
   logic             in_h1_s;
   logic             in_h2_s;
   logic             in_pl_s;
   logic             cnt_fits_s;
   logic             has_msg_s;

   keep_thermo_cnt #(
      .D_W  (AXI_KEEP_W),
      .D_LW (KEEP_LW)
   ) u_keep_cnt (
      .data_i (axis_tkeep_i),
      .cnt_o  (beat_len_s)
   );

   // Header phase tracker: advances on each accepted beat, tlast restarts
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_r <= H0;
      end else if (axis_tvalid_i) begin
         if (axis_tlast_i) begin
            state_r <= H0;
         end else begin
            case (state_r)
               H0:      state_r <= H1;
               H1:      state_r <= H2;
               H2:      state_r <= PAYLOAD;
               PAYLOAD: state_r <= PAYLOAD;
               default: state_r <= H0;
            endcase
         end
      end else begin
         state_r <= state_r;
      end
   end

   // A beat only counts outside reset; this gates every qualifier
   assign beat_ok_s  = nreset & axis_tvalid_i;
   assign in_h0_s    = beat_ok_s & (state_r == H0);
   assign in_h1_s    = beat_ok_s & (state_r == H1);
   assign in_h2_s    = beat_ok_s & (state_r == H2);
   assign in_pl_s    = beat_ok_s & (state_r == PAYLOAD);
   assign cnt_fits_s = (beat_len_s >= KEEP_LW'(CNT_END_LANE));
   assign has_msg_s  = (beat_len_s >  KEEP_LW'(MSG_LANE));

   assign axis_tready_o  = 1'b1;
   assign beat_len_o     = beat_len_s;

   assign sid_p0_v_o     = in_h0_s;
   assign sid_p0_o       = in_h0_s ? axis_tdata_i[SID0_LO_BIT +: 64] : 64'd0;

   assign sid_p1_v_o     = in_h1_s;
   assign sid_p1_o       = in_h1_s ? axis_tdata_i[15:0] : 16'd0;
   assign seq_num_p0_v_o = in_h1_s;
   assign seq_num_p0_o   = in_h1_s ? axis_tdata_i[SEQ0_LO_BIT +: 48] : 48'd0;

   assign seq_num_p1_v_o = in_h2_s;
   assign seq_num_p1_o   = in_h2_s ? axis_tdata_i[15:0] : 16'd0;

   assign msg_cnt_v_o    = in_h2_s & cnt_fits_s;
   assign msg_cnt_o      = msg_cnt_v_o ? axis_tdata_i[CNT_LO_BIT +: ML_W] : {ML_W{1'b0}};
   assign eos_o          = msg_cnt_v_o & (msg_cnt_o == MSG_CNT_EOS);

   // Bytes 20+ of H2 already belong to the first message
   assign payload_v_o    = in_pl_s | (in_h2_s & has_msg_s);

   // Packet closed before the message count was fully delivered
   assign hdr_err_o      = axis_tlast_i & (in_h0_s | in_h1_s | (in_h2_s & ~cnt_fits_s));

endmodule

// File: tb/tb_mold_header_rx.sv
// Directed bench for mold_header_rx. Each step drives one cycle of inputs,
// pushes the reference expectation onto a queue, and checks the DUT's
// combinational outputs against the popped entry at the falling edge.
module tb_mold_header_rx;

   typedef struct packed {
      logic        tready;
      logic        sid0_v;
      logic [63:0] sid0;
      logic        sid1_v;
      logic [15:0] sid1;
      logic        seq0_v;
      logic [47:0] seq0;
      logic        seq1_v;
      logic [15:0] seq1;
      logic        cnt_v;
      logic [15:0] cnt;
      logic        eos;
      logic [3:0]  len;
      logic        pay_v;
      logic        err;
   } exp_t;

   logic        clk;
   logic        nreset;
   logic        tvalid;
   logic [7:0]  tkeep;
   logic [63:0] tdata;
   logic        tlast;
   logic        tready;
   logic        sid0_v, sid1_v, seq0_v, seq1_v, cnt_v, eos, pay_v, err;
   logic [63:0] sid0;
   logic [15:0] sid1, seq1, cnt;
   logic [47:0] seq0;
   logic [3:0]  len;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ref_state = 0;   // 0=H0 1=H1 2=H2 3=payload

   localparam logic [63:0] A = 64'h0706050403020100;
   localparam logic [63:0] B = 64'h0F0E0D0C0B0A0908;
   localparam logic [63:0] C = 64'h1716151413121110;
   localparam logic [63:0] D = 64'h1F1E1D1C1B1A1918;

   mold_header_rx dut (
      .clk            (clk),
      .nreset         (nreset),
      .axis_tvalid_i  (tvalid),
      .axis_tkeep_i   (tkeep),
      .axis_tdata_i   (tdata),
      .axis_tlast_i   (tlast),
      .axis_tready_o  (tready),
      .sid_p0_v_o     (sid0_v),
      .sid_p0_o       (sid0),
      .sid_p1_v_o     (sid1_v),
      .sid_p1_o       (sid1),
      .seq_num_p0_v_o (seq0_v),
      .seq_num_p0_o   (seq0),
      .seq_num_p1_v_o (seq1_v),
      .seq_num_p1_o   (seq1),
      .msg_cnt_v_o    (cnt_v),
      .msg_cnt_o      (cnt),
      .eos_o          (eos),
      .beat_len_o     (len),
      .payload_v_o    (pay_v),
      .hdr_err_o      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] ref_len(input logic [7:0] k);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (k[i] == 1'b0) break;
         n = n + 4'd1;
      end
      return n;
   endfunction

   function automatic exp_t ref_model(input int st, input logic rst_n, input logic v,
                                      input logic [7:0] k, input logic [63:0] d,
                                      input logic l);
      exp_t e;
      e = '0;
      e.tready = 1'b1;
      e.len = ref_len(k);
      if (rst_n && v) begin
         if (st == 0) begin
            e.sid0_v = 1'b1; e.sid0 = d; e.err = l;
         end else if (st == 1) begin
            e.sid1_v = 1'b1; e.sid1 = d[15:0];
            e.seq0_v = 1'b1; e.seq0 = d[63:16];
            e.err = l;
         end else if (st == 2) begin
            e.seq1_v = 1'b1; e.seq1 = d[15:0];
            if (e.len >= 4'd4) begin
               e.cnt_v = 1'b1; e.cnt = d[31:16];
               e.eos = (d[31:16] == 16'hFFFF);
            end
            e.pay_v = (e.len > 4'd4);
            e.err = l && (e.len < 4'd4);
         end else begin
            e.pay_v = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic rst_n, input logic v, input logic [7:0] k,
                       input logic [63:0] d, input logic l);
      exp_t e;
      @(posedge clk);
      #1;
      nreset = rst_n; tvalid = v; tkeep = k; tdata = d; tlast = l;
      exp_q.push_back(ref_model(ref_state, rst_n, v, k, d, l));
      @(negedge clk);
      e = exp_q.pop_front();
      check("tready",  {63'd0, tready}, {63'd0, e.tready});
      check("sid0_v",  {63'd0, sid0_v}, {63'd0, e.sid0_v});
      check("sid0",    sid0,            e.sid0);
      check("sid1_v",  {63'd0, sid1_v}, {63'd0, e.sid1_v});
      check("sid1",    {48'd0, sid1},   {48'd0, e.sid1});
      check("seq0_v",  {63'd0, seq0_v}, {63'd0, e.seq0_v});
      check("seq0",    {16'd0, seq0},   {16'd0, e.seq0});
      check("seq1_v",  {63'd0, seq1_v}, {63'd0, e.seq1_v});
      check("seq1",    {48'd0, seq1},   {48'd0, e.seq1});
      check("cnt_v",   {63'd0, cnt_v},  {63'd0, e.cnt_v});
      check("cnt",     {48'd0, cnt},    {48'd0, e.cnt});
      check("eos",     {63'd0, eos},    {63'd0, e.eos});
      check("len",     {60'd0, len},    {60'd0, e.len});
      check("payload", {63'd0, pay_v},  {63'd0, e.pay_v});
      check("hdr_err", {63'd0, err},    {63'd0, e.err});
      // Advance the reference phase exactly as the next clock edge will
      if (!rst_n) ref_state = 0;
      else if (v && l) ref_state = 0;
      else if (v && ref_state < 3) ref_state = ref_state + 1;
   endtask

   initial begin
      logic [63:0] hb;
      logic [63:0] eosb;
      logic [7:0]  keeps [9];
      nreset = 1'b0; tvalid = 1'b0; tkeep = 8'h00; tdata = 64'd0; tlast = 1'b0;

      // Reset with live beats: every qualifier forced low
      step(1'b0, 1'b1, 8'hFF, A, 1'b0);
      step(1'b0, 1'b1, 8'hFF, B, 1'b1);

      // Full packet
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      check("tp_sid0", sid0, A);
      step(1'b1, 1'b1, 8'hFF, B, 1'b0);
      check("tp_sid1", {48'd0, sid1}, 64'h0908);
      check("tp_seq0", {16'd0, seq0}, 64'h0F0E0D0C0B0A);
      step(1'b1, 1'b1, 8'hFF, C, 1'b0);
      check("tp_seq1", {48'd0, seq1}, 64'h1110);
      check("tp_cnt",  {48'd0, cnt},  64'h1312);
      step(1'b1, 1'b1, 8'hFF, D, 1'b1);

      // Heartbeat: 20 bytes, count zero
      hb = 64'h0000_0000_0000_2222;
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      step(1'b1, 1'b1, 8'hFF, B, 1'b0);
      step(1'b1, 1'b1, 8'h0F, hb, 1'b1);
      check("hb_cnt_v", {63'd0, cnt_v}, 64'd1);

      // Truncated header on H1, then a fresh packet ending in end-of-session
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      step(1'b1, 1'b1, 8'hFF, B, 1'b1);
      check("trunc_err", {63'd0, err}, 64'd1);
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      step(1'b1, 1'b1, 8'hFF, B, 1'b0);
      eosb = 64'h1716_1514_FFFF_1110;
      step(1'b1, 1'b1, 8'hFF, eosb, 1'b1);
      check("eos_seen", {63'd0, eos}, 64'd1);

      // Single-beat packet and short H2 are header errors
      step(1'b1, 1'b1, 8'hFF, A, 1'b1);
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      step(1'b1, 1'b1, 8'hFF, B, 1'b0);
      step(1'b1, 1'b1, 8'h07, C, 1'b1);

      // Bubbles between header beats, including an idle tlast
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      step(1'b1, 1'b0, 8'hFF, B, 1'b1);
      step(1'b1, 1'b1, 8'hFF, B, 1'b0);
      step(1'b1, 1'b0, 8'h00, C, 1'b0);
      step(1'b1, 1'b0, 8'hFF, C, 1'b0);
      step(1'b1, 1'b1, 8'h3F, C, 1'b0);
      step(1'b1, 1'b1, 8'hFF, D, 1'b0);
      step(1'b1, 1'b1, 8'h03, D, 1'b1);

      // Reset mid-packet, next beat must be H0
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      step(1'b1, 1'b1, 8'hFF, B, 1'b0);
      step(1'b0, 1'b1, 8'hFF, C, 1'b0);
      step(1'b1, 1'b1, 8'hFF, A, 1'b0);
      check("post_rst_h0", {63'd0, sid0_v}, 64'd1);
      step(1'b1, 1'b1, 8'hFF, B, 1'b1);

      // Thermometer decode on idle cycles, plus a hole in the keep
      keeps = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, keeps[i], D, 1'b0);
         check("thermo", {60'd0, len}, 64'(i));
      end
      step(1'b1, 1'b0, 8'h0B, D, 1'b0);
      check("thermo_hole", {60'd0, len}, 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mold_header_rx.md
Name: mold_header_rx

Overview:
- Ingress parser for MoldUDP64 packets arriving as 64-bit AXI-Stream beats from the UDP stack.
- Tracks header beat phase (H0/H1/H2) with a small FSM and extracts session, sequence number and message count fields combinationally from the current beat.
- Reports the byte count of every beat, decoded from the tkeep thermometer code.
- Sits ahead of the message splitter, which consumes msg_cnt_o, beat_len_o and the payload beats.

Parameters:
- AXI_DATA_W, 64, tdata width; only 64 is supported.
- AXI_KEEP_W, 8, tkeep width (AXI_DATA_W/8).
- KEEP_LW, 4, width of beat_len_o ($clog2(AXI_KEEP_W)+1).
- ML_W, 16, message count width.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- axis_tvalid_i  in  1  beat valid
- axis_tkeep_i  in  AXI_KEEP_W  byte enables, thermometer from bit 0
- axis_tdata_i  in  AXI_DATA_W  data; wire byte n of the beat on bits [8n+7:8n]
- axis_tlast_i  in  1  last beat of UDP payload
- axis_tready_o  out  1  constant 1
- sid_p0_v_o / sid_p0_o  out  1 / 64  session bytes 0-7 = tdata[63:0] of beat H0
- sid_p1_v_o / sid_p1_o  out  1 / 16  session bytes 8-9 = tdata[15:0] of beat H1
- seq_num_p0_v_o / seq_num_p0_o  out  1 / 48  sequence bytes 0-5 = tdata[63:16] of H1
- seq_num_p1_v_o / seq_num_p1_o  out  1 / 16  sequence bytes 6-7 = tdata[15:0] of H2
- msg_cnt_v_o / msg_cnt_o  out  1 / ML_W  message count = tdata[31:16] of H2
- eos_o  out  1  msg_cnt_v_o and msg_cnt_o==16'hFFFF (end of session)
- beat_len_o  out  KEEP_LW  number of valid bytes in the current beat (0..8)
- payload_v_o  out  1  current beat is post-header payload
- hdr_err_o  out  1  packet ended before the header was complete

Behaviour:
- Reset:
  - Clock is clk; reset is nreset, synchronous, active-low.
  - Reset puts the FSM in H0.
  - While nreset=0, every *_v_o, eos_o, payload_v_o and hdr_err_o is forced to 0.
- FSM states and transitions (only on beats with axis_tvalid_i=1):
  - H0 -> H1.
  - H1 -> H2.
  - H2 -> PAYLOAD.
  - PAYLOAD -> PAYLOAD.
  - A beat with axis_tlast_i=1 in any state returns the FSM to H0 next cycle; this overrides the above.
  - Cycles with axis_tvalid_i=0 hold the state.
- Outputs are combinational from the current beat and state (zero latency); no field is registered.
  - sid_p0_v_o = tvalid & H0.
  - sid_p1_v_o = seq_num_p0_v_o = tvalid & H1.
  - seq_num_p1_v_o = tvalid & H2.
  - msg_cnt_v_o = tvalid & H2 & beat_len_o>=4.
  - payload_v_o = tvalid & PAYLOAD, plus tvalid & H2 & beat_len_o>4 (bytes 20+ of H2 belong to the first message).
- Field data outputs are zero whenever their valid is 0.
  - Bytes are passed in lane order with no endian swap; conversion is the consumer's job.
- hdr_err_o is a single-cycle pulse when tvalid & tlast and either:
  - the state is H0 or H1, or
  - the state is H2 with beat_len_o<4.
  - A 20-byte heartbeat (H2, tkeep=8'h0F, tlast) is legal: no error, msg_cnt_v_o=1.
- beat_len_o comes from the thermometer counter. It equals the length of the run of ones starting at tkeep[0], counting from bit 0. Example: 8'h00->0, 8'h0F->4, 8'hFF->8.
  - For non-thermometer input, only that leading run counts: 8'b0000_1011 -> 2.
  - beat_len_o is computed regardless of tvalid.
- axis_tready_o is always 1; no backpressure.

Decomposition:
- Shared package mold_pkg holds:
  - AXI_DATA_W, AXI_KEEP_W, ML_W;
  - the header byte offsets (SID 0, SEQ 10, CNT 18, first MSG_LEN 20);
  - the MSG_CNT_EOS constant 16'hFFFF;
  - the FSM state enum {H0,H1,H2,PAYLOAD}.
- One sub-module: keep_thermo_cnt (param D_W, D_LW; input data_i, output cnt_o), purely combinational. It is instantiated for beat_len_o.

Test Plan:
- Full packet: beats A=64'h0706050403020100, B=64'h0F0E0D0C0B0A0908, C=64'h1716151413121110 with tkeep=FF, then D with tlast.
  - Cycle A: sid_p0_o=A.
  - Cycle B: sid_p1_o=16'h0908, seq_num_p0_o=48'h0F0E0D0C0B0A.
  - Cycle C: seq_num_p1_o=16'h1110, msg_cnt_o=16'h1312, payload_v_o=1.
  - Cycle D: payload_v_o=1; FSM in H0 the next cycle.
- Heartbeat: third beat tkeep=8'h0F, tlast, tdata[31:16]=0 -> msg_cnt_v_o=1, msg_cnt_o=0, payload_v_o=0, hdr_err_o=0, FSM back to H0.
- Truncated header: tlast on beat H1 -> hdr_err_o=1 for that cycle; the next beat asserts sid_p0_v_o.
- End of session: H2 tdata[31:16]=16'hFFFF -> eos_o=1.
- Bubbles and reset: tvalid gaps between H0/H1/H2 hold the phase with all valids 0. Drive nreset=0 mid-packet -> all valids 0, and the next beat after release is H0.
- Thermo count: tkeep 00,01,03,07,0F,1F,3F,7F,FF -> beat_len_o 0..8; tkeep 8'h0B -> 2.
